// File: rtl/change_dispenser_if.sv
// Change dispenser bus: request handshake from the vending controller, coin ejector
// handshake, and status/stock reporting.
interface change_dispenser_if;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       change_ready;
    logic       refill;
    logic [2:0] coin_out;
    logic       coin_ack;
    logic       done;
    logic       short;
    logic       jam;
    logic [7:0] remaining;
    logic [7:0] stock_hi;
    logic [7:0] stock_mid;
    logic [7:0] stock_lo;

    modport master (
        output change_valid, change_amt, refill, coin_ack,
        input  change_ready, coin_out, done, short, jam, remaining,
        input  stock_hi, stock_mid, stock_lo
    );

    modport slave (
        input  change_valid, change_amt, refill, coin_ack,
        output change_ready, coin_out, done, short, jam, remaining,
        output stock_hi, stock_mid, stock_lo
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: ejects one coin at a time (largest stocked denomination that fits),
// tracks per-denomination stock and reports done, shortfall and ejector jam.
module change_dispenser #(
    parameter int unsigned DEN_HI      = 5,
    parameter int unsigned DEN_MID     = 2,
    parameter int unsigned DEN_LO      = 1,
    parameter logic [7:0]  STOCK_INIT  = 8'd20,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    change_dispenser_if.slave  bus
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StSelect, StEject, StDone, StFail} state_e;

    state_e            state_q;
    logic              ready_q;
    logic [2:0]        coin_out_q;
    logic              done_q;
    logic              short_q;
    logic              jam_q;
    logic [7:0]        remaining_q;
    logic [7:0]        stock_hi_q;
    logic [7:0]        stock_mid_q;
    logic [7:0]        stock_lo_q;
    logic [CntW-1:0]   cnt_q;

    logic       fit_hi;
    logic       fit_mid;
    logic       fit_lo;
    logic [7:0] coin_val;

    assign fit_hi  = (stock_hi_q  != 8'd0) && (remaining_q >= 8'(DEN_HI));
    assign fit_mid = (stock_mid_q != 8'd0) && (remaining_q >= 8'(DEN_MID));
    assign fit_lo  = (stock_lo_q  != 8'd0) && (remaining_q >= 8'(DEN_LO));

    always_comb begin
        coin_val = 8'd0;
        unique case (coin_out_q)
            3'b100:  coin_val = 8'(DEN_HI);
            3'b010:  coin_val = 8'(DEN_MID);
            3'b001:  coin_val = 8'(DEN_LO);
            default: coin_val = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            coin_out_q  <= 3'b000;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            jam_q       <= 1'b0;
            remaining_q <= 8'd0;
            stock_hi_q  <= STOCK_INIT;
            stock_mid_q <= STOCK_INIT;
            stock_lo_q  <= STOCK_INIT;
            cnt_q       <= '0;
        end else begin
            done_q  <= 1'b0;
            short_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.refill) begin
                        stock_hi_q  <= STOCK_INIT;
                        stock_mid_q <= STOCK_INIT;
                        stock_lo_q  <= STOCK_INIT;
                        jam_q       <= 1'b0;
                    end
                    if (bus.change_valid && ready_q) begin
                        remaining_q <= bus.change_amt;
                        ready_q     <= 1'b0;
                        state_q     <= StSelect;
                    end
                end
                StSelect: begin
                    cnt_q <= '0;
                    if (remaining_q == 8'd0) begin
                        state_q <= StDone;
                    end else if (jam_q) begin
                        state_q <= StFail;
                    end else if (fit_hi) begin
                        coin_out_q <= 3'b100;
                        state_q    <= StEject;
                    end else if (fit_mid) begin
                        coin_out_q <= 3'b010;
                        state_q    <= StEject;
                    end else if (fit_lo) begin
                        coin_out_q <= 3'b001;
                        state_q    <= StEject;
                    end else begin
                        state_q <= StFail;
                    end
                end
                StEject: begin
                    if (bus.coin_ack) begin
                        remaining_q <= remaining_q - coin_val;
                        if (coin_out_q[2]) stock_hi_q  <= stock_hi_q  - 8'd1;
                        if (coin_out_q[1]) stock_mid_q <= stock_mid_q - 8'd1;
                        if (coin_out_q[0]) stock_lo_q  <= stock_lo_q  - 8'd1;
                        coin_out_q <= 3'b000;
                        cnt_q      <= '0;
                        state_q    <= StSelect;
                    end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                        // Coin never confirmed: leave stock and remaining untouched.
                        coin_out_q <= 3'b000;
                        jam_q      <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= StFail;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    done_q      <= 1'b1;
                    remaining_q <= 8'd0;
                    ready_q     <= 1'b1;
                    state_q     <= StIdle;
                end
                StFail: begin
                    short_q <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    coin_out_q <= 3'b000;
                    ready_q    <= 1'b1;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

    assign bus.change_ready = ready_q;
    assign bus.coin_out     = coin_out_q;
    assign bus.done         = done_q;
    assign bus.short        = short_q;
    assign bus.jam          = jam_q;
    assign bus.remaining    = remaining_q;
    assign bus.stock_hi     = stock_hi_q;
    assign bus.stock_mid    = stock_mid_q;
    assign bus.stock_lo     = stock_lo_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected coins/completions,
// a monitor pops and compares them as the DUT presents them.
module tb_change_dispenser;

    logic clk = 1'b0;
    logic rst_n;
    logic ack_auto;

    always #5 clk = ~clk;

    change_dispenser_if bus();

    change_dispenser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int         kind;  // 0 coin, 1 done, 2 short
        logic [2:0] coin;
        logic [7:0] rem;
        logic [7:0] shi;
        logic [7:0] smid;
        logic [7:0] slo;
        logic       jam;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_coin(input logic [2:0] c);
        exp_t e;
        e.kind = 0; e.coin = c; e.rem = 8'd0;
        e.shi = 8'd0; e.smid = 8'd0; e.slo = 8'd0; e.jam = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_end(input int kind, input int rem, input int shi, input int smid,
                            input int slo, input int jam);
        exp_t e;
        e.kind = kind; e.coin = 3'b000; e.rem = 8'(rem);
        e.shi = 8'(shi); e.smid = 8'(smid); e.slo = 8'(slo); e.jam = (jam != 0);
        exp_q.push_back(e);
    endtask

    task automatic request(input logic [7:0] amt);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.change_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.change_ready) check("ready_wait", 0, 1);
        bus.change_valid = 1'b1;
        bus.change_amt   = amt;
        @(posedge clk);
        #1 bus.change_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.change_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("idle_wait_pending", exp_q.size(), 0);
    endtask

    task automatic wait_coin(input logic [2:0] c);
        int n;
        n = 0;
        while (bus.coin_out != c && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.coin_out != c) check("coin_wait", int'(bus.coin_out), int'(c));
    endtask

    task automatic ack_once();
        @(negedge clk);
        bus.coin_ack = 1'b1;
        @(posedge clk);
        #1 bus.coin_ack = 1'b0;
    endtask

    task automatic refill_pulse();
        @(negedge clk);
        bus.refill = 1'b1;
        @(posedge clk);
        #1 bus.refill = 1'b0;
    endtask

    // Ejector model: confirm any pending coin on the following edge.
    initial begin
        forever begin
            @(negedge clk);
            if (ack_auto) bus.coin_ack = (bus.coin_out != 3'b000);
        end
    end

    // Monitor: compare every coin start and every done/short pulse against the queue.
    initial begin
        logic [2:0] prev;
        exp_t       e;
        prev = 3'b000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 3'b000;
            end else begin
                if (bus.coin_out != 3'b000 && prev == 3'b000) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_coin", int'(bus.coin_out), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_coin", 0, e.kind);
                        check("coin_out", int'(bus.coin_out), int'(e.coin));
                    end
                end
                if (bus.done || bus.short) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_end", int'({bus.done, bus.short}), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_end", bus.done ? 1 : 2, e.kind);
                        check("end_remaining", int'(bus.remaining), int'(e.rem));
                        check("end_stock_hi", int'(bus.stock_hi), int'(e.shi));
                        check("end_stock_mid", int'(bus.stock_mid), int'(e.smid));
                        check("end_stock_lo", int'(bus.stock_lo), int'(e.slo));
                        check("end_jam", int'(bus.jam), int'(e.jam));
                    end
                end
                prev = bus.coin_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        rst_n            = 1'b0;
        ack_auto         = 1'b1;
        bus.change_valid = 1'b0;
        bus.change_amt   = 8'd0;
        bus.refill       = 1'b0;
        bus.coin_ack     = 1'b0;
        #8;
        check("rst_ready", int'(bus.change_ready), 1);
        check("rst_coin_out", int'(bus.coin_out), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_short", int'(bus.short), 0);
        check("rst_jam", int'(bus.jam), 0);
        check("rst_remaining", int'(bus.remaining), 0);
        check("rst_stock_hi", int'(bus.stock_hi), 20);
        check("rst_stock_mid", int'(bus.stock_mid), 20);
        check("rst_stock_lo", int'(bus.stock_lo), 20);
        #4 rst_n = 1'b1;

        // 8 = 5 + 2 + 1
        push_coin(3'b100); push_coin(3'b010); push_coin(3'b001);
        push_end(1, 0, 19, 19, 19, 0);
        request(8'd8);
        wait_idle();

        // Drain all 19 hi coins, then 7 must fall through to mid coins.
        for (int i = 0; i < 19; i++) push_coin(3'b100);
        push_end(1, 0, 0, 19, 19, 0);
        request(8'd95);
        wait_idle();
        push_coin(3'b010); push_coin(3'b010); push_coin(3'b010); push_coin(3'b001);
        push_end(1, 0, 0, 16, 18, 0);
        request(8'd7);
        wait_idle();

        // Drain mid completely and lo down to one, then shortfall on 3.
        for (int i = 0; i < 16; i++) push_coin(3'b010);
        push_end(1, 0, 0, 0, 18, 0);
        request(8'd32);
        wait_idle();
        for (int i = 0; i < 17; i++) push_coin(3'b001);
        push_end(1, 0, 0, 0, 1, 0);
        request(8'd17);
        wait_idle();
        push_coin(3'b001);
        push_end(2, 2, 0, 0, 0, 0);
        request(8'd3);
        wait_idle();
        refill_pulse();
        @(negedge clk);
        check("refill_stock_hi", int'(bus.stock_hi), 20);
        check("refill_stock_mid", int'(bus.stock_mid), 20);
        check("refill_stock_lo", int'(bus.stock_lo), 20);

        // Ack timeout: coin held 16 cycles, then jam and short with nothing consumed.
        ack_auto     = 1'b0;
        bus.coin_ack = 1'b0;
        push_coin(3'b100);
        push_end(2, 5, 20, 20, 20, 1);
        request(8'd5);
        wait_coin(3'b100);
        held = 0;
        while (bus.coin_out == 3'b100 && held < 40) begin
            held++;
            @(negedge clk);
        end
        check("eject_hold_cycles", held, 16);
        wait_idle();
        push_end(2, 1, 20, 20, 20, 1);
        request(8'd1);
        wait_idle();
        refill_pulse();
        @(negedge clk);
        check("refill_clears_jam", int'(bus.jam), 0);
        ack_auto = 1'b1;

        // Zero amount: done two edges after acceptance.
        push_end(1, 0, 20, 20, 20, 0);
        request(8'd0);
        @(posedge clk);
        #1 check("zero_done_early", int'(bus.done), 0);
        @(posedge clk);
        #1 check("zero_done_latency", int'(bus.done), 1);
        wait_idle();

        // Request during EJECT is not accepted; refill during payout is ignored.
        ack_auto = 1'b0;
        push_coin(3'b100); push_coin(3'b010);
        push_end(1, 0, 19, 19, 20, 0);
        request(8'd7);
        wait_coin(3'b100);
        bus.change_valid = 1'b1;
        bus.change_amt   = 8'd9;
        repeat (2) begin
            @(negedge clk);
            check("eject_ready_low", int'(bus.change_ready), 0);
        end
        bus.change_valid = 1'b0;
        ack_once();
        wait_coin(3'b010);
        refill_pulse();
        ack_once();
        wait_idle();

        // Asynchronous reset in the middle of EJECT.
        push_coin(3'b100);
        request(8'd5);
        wait_coin(3'b100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_coin_out", int'(bus.coin_out), 0);
        check("async_rst_ready", int'(bus.change_ready), 1);
        check("async_rst_remaining", int'(bus.remaining), 0);
        check("async_rst_stock_hi", int'(bus.stock_hi), 20);
        check("queue_drained", exp_q.size(), 0);
        #4 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
